// File: rtl/pkt_stream_arbiter.sv
// pkt_stream_arbiter: round-robin arbiter that locks one source per packet (size beat, then body to tlast).
// Define PKT_ARB_STATS_EN to enable the completed-packet counter on pkt_count; otherwise it is tied to 0.
module pkt_stream_arbiter #(
  parameter int DW = 128,
  parameter int N  = 4,
  localparam int GW = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [N*16-1:0]   s_psize_tdata,
  input  logic [N-1:0]      s_psize_tvalid,
  output logic [N-1:0]      s_psize_tready,
  input  logic [N*DW-1:0]   s_pbody_tdata,
  input  logic [N*DW/8-1:0] s_pbody_tkeep,
  input  logic [N-1:0]      s_pbody_tlast,
  input  logic [N-1:0]      s_pbody_tvalid,
  output logic [N-1:0]      s_pbody_tready,
  output logic [15:0]       m_psize_tdata,
  output logic              m_psize_tvalid,
  input  logic              m_psize_tready,
  output logic [DW-1:0]     m_pbody_tdata,
  output logic [DW/8-1:0]   m_pbody_tkeep,
  output logic              m_pbody_tlast,
  output logic              m_pbody_tvalid,
  input  logic              m_pbody_tready,
  output logic [GW-1:0]     grant,
  output logic              busy,
  output logic [15:0]       pkt_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, SIZE = 2'd1, BODY = 2'd2} state_t;

  state_t        state_reg, state_next;
  logic [GW-1:0] grant_reg, grant_next;
  logic [GW-1:0] rr_reg, rr_next;
  logic [GW-1:0] pick;

  logic [15:0]     size_arr [N];
  logic [DW-1:0]   data_arr [N];
  logic [DW/8-1:0] keep_arr [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign size_arr[gi] = s_psize_tdata[16*gi +: 16];
    assign data_arr[gi] = s_pbody_tdata[DW*gi +: DW];
    assign keep_arr[gi] = s_pbody_tkeep[(DW/8)*gi +: DW/8];
  end

  // Scan from the farthest offset down so the nearest requester after rr wins.
  always_comb begin
    logic [GW-1:0] cand;
    pick = rr_reg;
    cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = GW'((int'(rr_reg) + k) % N);
      if (s_psize_tvalid[cand]) pick = cand;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      rr_reg    <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      rr_reg    <= rr_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    rr_next        = rr_reg;
    s_psize_tready = '0;
    s_pbody_tready = '0;
    m_psize_tdata  = '0;
    m_psize_tvalid = 1'b0;
    m_pbody_tdata  = '0;
    m_pbody_tkeep  = '0;
    m_pbody_tlast  = 1'b0;
    m_pbody_tvalid = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|s_psize_tvalid) begin
          grant_next = pick;
          state_next = SIZE;
        end
      end
      SIZE: begin
        m_psize_tdata             = size_arr[grant_reg];
        m_psize_tvalid            = s_psize_tvalid[grant_reg];
        s_psize_tready[grant_reg] = m_psize_tready;
        if (s_psize_tvalid[grant_reg] && m_psize_tready) state_next = BODY;
      end
      BODY: begin
        m_pbody_tdata             = data_arr[grant_reg];
        m_pbody_tkeep             = keep_arr[grant_reg];
        m_pbody_tlast             = s_pbody_tlast[grant_reg];
        m_pbody_tvalid            = s_pbody_tvalid[grant_reg];
        s_pbody_tready[grant_reg] = m_pbody_tready;
        if (s_pbody_tvalid[grant_reg] && m_pbody_tready && s_pbody_tlast[grant_reg]) begin
          state_next = IDLE;
          rr_next    = (grant_reg == GW'(N - 1)) ? '0 : grant_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign grant = grant_reg;
  assign busy  = (state_reg != IDLE);

`ifdef PKT_ARB_STATS_EN
  // Body outputs are zero outside BODY, so this is exactly the end-of-packet handshake.
  logic        pkt_done;
  logic [15:0] cnt_reg;
  assign pkt_done = m_pbody_tvalid & m_pbody_tready & m_pbody_tlast;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)       cnt_reg <= '0;
    else if (pkt_done) cnt_reg <= cnt_reg + 16'd1;
  end
  assign pkt_count = cnt_reg;
`else
  assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_pkt_stream_arbiter.sv
// Scoreboard bench for pkt_stream_arbiter: source models feed packets, a negedge monitor checks every output beat.
module tb_pkt_stream_arbiter;
  localparam int N  = 4;
  localparam int DW = 128;
  localparam int KW = DW / 8;

  logic clk = 1'b0;
  logic resetn = 1'b1;

  logic [N*16-1:0] s_psize_tdata;
  logic [N-1:0]    s_psize_tvalid, s_psize_tready;
  logic [N*DW-1:0] s_pbody_tdata;
  logic [N*KW-1:0] s_pbody_tkeep;
  logic [N-1:0]    s_pbody_tlast, s_pbody_tvalid, s_pbody_tready;
  logic [15:0]     m_psize_tdata;
  logic            m_psize_tvalid;
  logic            m_psize_tready = 1'b1;
  logic [DW-1:0]   m_pbody_tdata;
  logic [KW-1:0]   m_pbody_tkeep;
  logic            m_pbody_tlast, m_pbody_tvalid;
  logic            m_pbody_tready = 1'b1;
  logic [1:0]      grant;
  logic            busy;
  logic [15:0]     pkt_count;

  pkt_stream_arbiter #(.DW(DW), .N(N)) dut (
    .clk(clk), .resetn(resetn),
    .s_psize_tdata(s_psize_tdata), .s_psize_tvalid(s_psize_tvalid), .s_psize_tready(s_psize_tready),
    .s_pbody_tdata(s_pbody_tdata), .s_pbody_tkeep(s_pbody_tkeep), .s_pbody_tlast(s_pbody_tlast),
    .s_pbody_tvalid(s_pbody_tvalid), .s_pbody_tready(s_pbody_tready),
    .m_psize_tdata(m_psize_tdata), .m_psize_tvalid(m_psize_tvalid), .m_psize_tready(m_psize_tready),
    .m_pbody_tdata(m_pbody_tdata), .m_pbody_tkeep(m_pbody_tkeep), .m_pbody_tlast(m_pbody_tlast),
    .m_pbody_tvalid(m_pbody_tvalid), .m_pbody_tready(m_pbody_tready),
    .grant(grant), .busy(busy), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Source models: bench-owned request counts, model-owned progress
  int          req_cnt  [N] = '{default: 0};
  int          len_cfg  [N] = '{default: 1};
  logic [15:0] size_cfg [N] = '{default: 16'h0};
  logic        hold     [N] = '{default: 1'b0};
  int          done_cnt [N] = '{default: 0};
  int          beat     [N] = '{default: 0};
  logic        phase    [N] = '{default: 1'b0};

  for (genvar gi = 0; gi < N; gi++) begin : g_src
    logic pend;
    assign pend = (req_cnt[gi] != done_cnt[gi]);
    assign s_psize_tvalid[gi] = pend && !phase[gi] && !hold[gi];
    assign s_psize_tdata[16*gi +: 16] = size_cfg[gi];
    assign s_pbody_tvalid[gi] = pend && (phase[gi] || hold[gi]);
    assign s_pbody_tlast[gi] = (beat[gi] == len_cfg[gi] - 1);
    assign s_pbody_tkeep[KW*gi +: KW] = s_pbody_tlast[gi] ? 16'h00FF : 16'hFFFF;
    assign s_pbody_tdata[DW*gi +: DW] = {{(DW-24){1'b0}}, 8'(gi), 8'(done_cnt[gi]), 8'(beat[gi])};
  end

  always @(posedge clk or negedge resetn) begin
    for (int i = 0; i < N; i++) begin
      if (!resetn) begin
        done_cnt[i] <= req_cnt[i];
        phase[i]    <= 1'b0;
        beat[i]     <= 0;
      end else if (s_psize_tvalid[i] && s_psize_tready[i]) begin
        phase[i] <= 1'b1;
        beat[i]  <= 0;
      end else if (phase[i] && s_pbody_tvalid[i] && s_pbody_tready[i]) begin
        if (s_pbody_tlast[i]) begin
          done_cnt[i] <= done_cnt[i] + 1;
          phase[i]    <= 1'b0;
          beat[i]     <= 0;
        end else begin
          beat[i] <= beat[i] + 1;
        end
      end
    end
  end

  // Scoreboard
  typedef struct {
    bit            body;
    int            src;
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    bit            last;
  } exp_t;
  exp_t exp_q[$];
  int   exp_pkt_no [N] = '{default: 0};

  task automatic expect_pkt(input int src, input int len, input logic [15:0] size);
    exp_t e;
    e.body = 1'b0; e.src = src; e.data = {{(DW-16){1'b0}}, size}; e.keep = '0; e.last = 1'b0;
    exp_q.push_back(e);
    for (int b = 0; b < len; b++) begin
      e.body = 1'b1;
      e.last = (b == len - 1);
      e.keep = e.last ? 16'h00FF : 16'hFFFF;
      e.data = {{(DW-24){1'b0}}, 8'(src), 8'(exp_pkt_no[src]), 8'(b)};
      exp_q.push_back(e);
    end
    exp_pkt_no[src]++;
  endtask

  task automatic load(input int src, input int cnt, input int len, input logic [15:0] size);
    len_cfg[src]  = len;
    size_cfg[src] = size;
    req_cnt[src]  = req_cnt[src] + cnt;
  endtask

  task automatic chk(input string name, input int got, input int req);
    tests++;
    if (got != req) begin
      fails++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    chk({name, "_drain"}, exp_q.size(), 0);
  endtask

  // Monitor
  bit gap_chk = 1'b0;
  int cyc = 0;
  int last_tlast = -1;
  int bodies = 0;

  initial begin
    exp_t e;
    logic [N-1:0] mask;
    forever begin
      @(negedge clk);
      if (resetn) begin
        cyc++;
        if (!gap_chk) last_tlast = -1;
        if (m_psize_tvalid && m_psize_tready) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL size_beat got src=%0d size=%h required none", grant, m_psize_tdata);
          end else begin
            e = exp_q.pop_front();
            if (e.body || e.src != int'(grant) || e.data[15:0] != m_psize_tdata) begin
              fails++;
              $display("FAIL size_beat got src=%0d size=%h required src=%0d size=%h body=%0d",
                       grant, m_psize_tdata, e.src, e.data[15:0], e.body);
            end
          end
          if (gap_chk && last_tlast >= 0) begin
            tests++;
            if (cyc - last_tlast != 2) begin
              fails++;
              $display("FAIL pkt_gap got=%0d required=2", cyc - last_tlast);
            end
          end
        end
        if (m_pbody_tvalid && m_pbody_tready) begin
          tests++;
          bodies++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL body_beat got src=%0d data=%h required none", grant, m_pbody_tdata);
          end else begin
            e = exp_q.pop_front();
            if (!e.body || e.src != int'(grant) || e.data != m_pbody_tdata ||
                e.keep != m_pbody_tkeep || e.last != m_pbody_tlast) begin
              fails++;
              $display("FAIL body_beat got src=%0d data=%h keep=%h last=%0d required src=%0d data=%h keep=%h last=%0d",
                       grant, m_pbody_tdata, m_pbody_tkeep, m_pbody_tlast, e.src, e.data, e.keep, e.last);
            end
          end
          if (m_pbody_tlast) begin
            last_tlast = cyc;
            $display("[TB] pkt done src=%0d cycle=%0d", grant, cyc);
          end
        end
        // Ready exclusivity and pass-through
        mask = ~(4'(1) << grant);
        tests++;
        if ((((s_psize_tready | s_pbody_tready) & mask) != '0) ||
            (!busy && ((s_psize_tready | s_pbody_tready) != '0)) ||
            (m_psize_tvalid && m_pbody_tvalid) ||
            (m_pbody_tvalid && (s_pbody_tready[grant] != m_pbody_tready)) ||
            (m_psize_tvalid && (s_psize_tready[grant] != m_psize_tready))) begin
          fails++;
          $display("FAIL ready_excl got sready=%b bready=%b mval=%b%b grant=%0d busy=%0d required only granted ready",
                   s_psize_tready, s_pbody_tready, m_psize_tvalid, m_pbody_tvalid, grant, busy);
        end
      end
    end
  end

  int exp_pkts = 0;
  function automatic int cnt_exp(input int n);
`ifdef PKT_ARB_STATS_EN
    return n % 65536;
`else
    return 0 * n;
`endif
  endfunction

  initial begin
    int base;
    int c;
    #1 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_readies", 32'({s_psize_tready, s_pbody_tready}), 0);
    chk("rst_mvalid", 32'({m_psize_tvalid, m_pbody_tvalid}), 0);
    chk("rst_pkt_count", 32'(pkt_count), 0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Single source 2
    expect_pkt(2, 4, 16'h0040);
    load(2, 1, 4, 16'h0040);
    #1;
    chk("single_idle_no_size", 32'(m_psize_tvalid), 0);
    @(posedge clk); #1;
    chk("single_size_valid", 32'(m_psize_tvalid), 1);
    chk("single_size_data", 32'(m_psize_tdata), 32'h0040);
    chk("single_grant", 32'(grant), 2);
    chk("single_busy", 32'(busy), 1);
    chk("single_no_body_ready", 32'(s_pbody_tready), 0);
    wait_drain("single", 40);
    exp_pkts += 1;

    // Fairness: rr=3 after source 2, so order 3,0,1,2,3,0,1,2
    gap_chk = 1'b1;
    for (int r = 0; r < 2; r++) begin
      expect_pkt(3, 2, 16'h0023);
      expect_pkt(0, 2, 16'h0020);
      expect_pkt(1, 2, 16'h0021);
      expect_pkt(2, 2, 16'h0022);
    end
    load(0, 2, 2, 16'h0020);
    load(1, 2, 2, 16'h0021);
    load(2, 2, 2, 16'h0022);
    load(3, 2, 2, 16'h0023);
    wait_drain("fair", 120);
    gap_chk = 1'b0;
    exp_pkts += 8;

    // Backpressure on a 3-beat body
    expect_pkt(1, 3, 16'h0030);
    load(1, 1, 3, 16'h0030);
    c = 0;
    while (exp_q.size() != 0 && c < 40) begin
      @(posedge clk); #1;
      if (busy && !m_psize_tvalid) m_pbody_tready = ~m_pbody_tready;
      c++;
    end
    chk("bp_drain", exp_q.size(), 0);
    m_pbody_tready = 1'b1;
    exp_pkts += 1;

    // Body-before-size: source 1 body only, source 3 size
    hold[1] = 1'b1;
    load(1, 1, 2, 16'h0012);
    expect_pkt(3, 2, 16'h0032);
    load(3, 1, 2, 16'h0032);
    wait_drain("bbs_src3", 40);
    repeat (3) begin
      @(posedge clk); #1;
      chk("bbs_idle_busy", 32'(busy), 0);
      chk("bbs_src1_ready", 32'(s_pbody_tready[1]), 0);
    end
    expect_pkt(1, 2, 16'h0012);
    hold[1] = 1'b0;
    wait_drain("bbs_src1", 40);
    exp_pkts += 2;
    chk("pkt_count_mid", 32'(pkt_count), cnt_exp(exp_pkts));

    // Reset in the middle of a 5-beat body
    expect_pkt(0, 5, 16'h0050);
    load(0, 1, 5, 16'h0050);
    base = bodies;
    c = 0;
    while (bodies < base + 2 && c < 40) begin
      @(posedge clk); #1;
      c++;
    end
    chk("rst_mid_beats", bodies - base, 2);
    resetn = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_readies", 32'({s_psize_tready, s_pbody_tready}), 0);
    chk("rst_mid_mvalid", 32'({m_psize_tvalid, m_pbody_tvalid}), 0);
    chk("rst_mid_pkt_count", 32'(pkt_count), 0);
    exp_q.delete();
    exp_pkts = 0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("rst_rel_busy", 32'(busy), 0);
    chk("rst_rel_grant", 32'(grant), 0);
    // rr must be back to 0: source 0 beats source 3
    expect_pkt(0, 1, 16'h0101);
    expect_pkt(3, 1, 16'h0301);
    load(3, 1, 1, 16'h0301);
    load(0, 1, 1, 16'h0101);
    wait_drain("rst_rr", 40);
    exp_pkts += 2;
    @(posedge clk); #1;
    chk("pkt_count_end", 32'(pkt_count), cnt_exp(exp_pkts));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pkt_stream_arbiter.md
# pkt_stream_arbiter

Round-robin packet arbiter that shares one header-insertion datapath among N upstream packet sources. Each source supplies a 16-bit packet-size stream and an AXI-Stream body; the arbiter locks onto one source for the whole packet (size beat, then body through `tlast`) and forwards both channels to the header-adding stage's `psize`/`pbody` inputs. It sits between the per-source packet FIFOs and the header-adding stage.

## Interface
- `DW`, 128, body data width in bits (multiple of 8)
- `N`, 4, number of sources (1..16)
- `clk` input 1, rising-edge clock
- `resetn` input 1, asynchronous active-low reset
- `s_psize_tdata` input N*16, source i size at bits [16i+15:16i]
- `s_psize_tvalid` input N, per-source size valid
- `s_psize_tready` output N, per-source size ready
- `s_pbody_tdata` input N*DW, source i body at [DW*i+DW-1:DW*i]
- `s_pbody_tkeep` input N*DW/8, per-source keep
- `s_pbody_tlast` input N, per-source last
- `s_pbody_tvalid` input N, per-source body valid
- `s_pbody_tready` output N, per-source body ready
- `m_psize_tdata` output 16, size to header stage
- `m_psize_tvalid` output 1
- `m_psize_tready` input 1
- `m_pbody_tdata` output DW, body to header stage
- `m_pbody_tkeep` output DW/8
- `m_pbody_tlast` output 1
- `m_pbody_tvalid` output 1
- `m_pbody_tready` input 1
- `grant` output clog2(N) (min 1), index of the locked source; valid outside IDLE
- `busy` output 1, high in SIZE or BODY
- `pkt_count` output 16, completed-packet counter (see Configuration)

## Operation
- Registered state: `state` ∈ {IDLE, SIZE, BODY}, `grant`, round-robin pointer `rr`. All reset to IDLE/0/0.
- IDLE: all `s_*_tready` = 0, all `m_*_tvalid` = 0. If any `s_psize_tvalid` is high, select the first asserted index scanning `rr`, `rr+1`, … modulo N. Register it into `grant`, go to SIZE. Body valid without size valid never wins arbitration.
- SIZE: `m_psize_*` = source `grant`'s size channel. `s_psize_tready[grant]` = `m_psize_tready`. All other readies = 0. `m_pbody_tvalid` = 0. A size handshake moves the FSM to BODY.
- BODY: `m_pbody_*` = source `grant`'s body channel. `s_pbody_tready[grant]` = `m_pbody_tready`. All other readies = 0. `m_psize_tvalid` = 0.
  - A handshake with `tlast` = 1 returns the FSM to IDLE and sets `rr` ← (`grant`+1) mod N.
- Data and keep outputs are combinational muxes. When the channel is not selected they drive 0.
- Size value is forwarded unchecked; body length is not compared against it.
- Only the granted source's `tready` can ever be high; at most one channel (size or body) is active per cycle.
- Reset mid-packet: FSM returns to IDLE immediately (async), all readies and valids deassert, and the partial packet is abandoned. Upstream flushing is the owner's responsibility.

## Timing
- Arbitration: 1 cycle (IDLE), so the first size beat is offered the cycle after IDLE sees `s_psize_tvalid`.
- Size→body: the body is offered the cycle after the size handshake.
- Minimum packet occupancy: 1 (IDLE) + 1 (SIZE) + B body beats, with a 1-cycle gap between packets.
- No pipeline registers on data: `m_*` to `s_*` paths are combinational within a state, giving zero-latency pass-through of `tready`/`tvalid`.
- `grant` and `busy` change only on clock edges.

## Configuration
- `PKT_ARB_STATS_EN` defined: `pkt_count` increments (wrapping 0xFFFF→0) on each body handshake with `tlast` in BODY. It resets to 0.
- Not defined: the counter logic is omitted and `pkt_count` is tied to 0.

## Test plan
- Single source: N=4, only src 2 sends size 0x0040 plus 4 beats -> `grant`=2, `m_psize_tdata`=0x0040 one cycle after valid, 4 body beats out, `tlast` on the 4th, then `rr`=3.
- Fairness: all 4 sources continuously valid with 2-beat packets -> grant order 0,1,2,3,0,… with exactly one IDLE cycle between packets.
- Backpressure: `m_pbody_tready` toggling 1010 during a 3-beat body -> `s_pbody_tready[grant]` mirrors it, no beat dropped or duplicated, other sources' readies stay 0.
- Body-before-size: src 1 asserts body valid only, src 3 asserts size -> src 3 granted and src 1 `tready` stays 0 until it presents a size.
- Reset mid-BODY: assert `resetn`=0 after 2 of 5 beats -> `busy`=0, all readies 0 without a clock edge. After release the FSM is IDLE with `rr`=0.
- Stats (`PKT_ARB_STATS_EN`): preload the counter to 0xFFFF by sending 65535 packets, then send 1 more -> `pkt_count`=0. Without the macro, `pkt_count` stays 0 throughout.
